// File: rtl/mem_arbiter.sv
// mem_arbiter -- four-core round-robin arbiter in front of one shared memory.
//
// A single transaction is in flight at a time: IDLE picks a winner, ISSUE
// strobes the memory for one cycle, WAIT covers the memory read latency and
// DONE pulses ready for the winner.
//
// Ports
//   clock      : clock, all state changes on its rising edge
//   reset      : asynchronous active-low reset
//   req        : per-core request level (bit i = core i)
//   we_in      : per-core write enable (1 = write, 0 = read)
//   addr_in    : per-core address, core i at [i*ADDR_W +: ADDR_W]
//   wdata_in   : per-core write data, core i at [i*DATA_W +: DATA_W]
//   gnt        : one-hot owner of the memory (0 while idle)
//   ready      : one-hot single-cycle completion pulse
//   rdata_out  : read data of the last completed read
//   busy       : a transaction is in progress
//   mem_en     : memory strobe, high only in ISSUE
//   mem_we     : memory write enable (latched)
//   mem_addr   : memory address (latched)
//   mem_wdata  : memory write data (latched)
//   mem_rdata  : memory read data, valid MEM_LAT cycles after the strobe
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [3:0]            we_in,
    input  logic [4*ADDR_W-1:0]   addr_in,
    input  logic [4*DATA_W-1:0]   wdata_in,
    output logic [3:0]            gnt,
    output logic [3:0]            ready,
    output logic [DATA_W-1:0]     rdata_out,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          ptr_reg, ptr_next;
    logic [1:0]          winner_reg, winner_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                after_done_reg;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;

    logic [ADDR_W-1:0]   addr_arr [4];
    logic [DATA_W-1:0]   wdata_arr [4];
    logic [3:0]          eligible;
    logic [3:0]          rot_req;
    logic [1:0]          offset;
    logic [1:0]          pick;
    logic                pick_valid;

    // Unpack the per-core buses and rotate the eligible set so that
    // rot_req[0] is the core at ptr, rot_req[1] the one after it, etc.
    for (genvar gi = 0; gi < 4; gi++) begin : g_core
        assign addr_arr[gi]  = addr_in[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = wdata_in[gi*DATA_W +: DATA_W];
        assign rot_req[gi]   = eligible[ptr_reg + 2'(gi)];
    end

    // The core just served sits out the single IDLE cycle right after DONE
    // so a requester that keeps req high cannot immediately win again.
    always_comb begin
        eligible = req;
        if (after_done_reg) begin
            eligible[winner_reg] = 1'b0;
        end
    end

    // Lowest rotated offset wins.
    always_comb begin
        offset     = 2'd0;
        pick_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset     = 2'(k);
                pick_valid = 1'b1;
            end
        end
        pick = ptr_reg + offset;
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        winner_next = winner_reg;
        cnt_next    = cnt_reg;
        we_next     = we_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        rdata_next  = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    winner_next = pick;
                    we_next     = we_in[pick];
                    addr_next   = addr_arr[pick];
                    wdata_next  = wdata_arr[pick];
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = 4'(MEM_LAT - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                    // mem_rdata is valid in this last WAIT cycle.
                    if (!we_reg) begin
                        rdata_next = mem_rdata;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                ptr_next   = winner_reg + 2'd1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= 2'd0;
            winner_reg     <= 2'd0;
            cnt_reg        <= 4'd0;
            after_done_reg <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            winner_reg     <= winner_next;
            cnt_reg        <= cnt_next;
            after_done_reg <= (state_reg == DONE);
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    assign busy      = (state_reg != IDLE);
    assign mem_en    = (state_reg == ISSUE);
    assign gnt       = busy ? (4'b0001 << winner_reg) : 4'b0000;
    assign ready     = (state_reg == DONE) ? (4'b0001 << winner_reg) : 4'b0000;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign rdata_out = rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed bench for mem_arbiter (MEM_LAT=2 main instance,
// plus MEM_LAT=1 and MEM_LAT=4 instances for the latency cases).
module tb_mem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic [3:0]          req, req_l, we_in;
    logic [4*ADDR_W-1:0] addr_in;
    logic [4*DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0]   mem_rdata;

    logic [3:0]          gnt, ready;
    logic [DATA_W-1:0]   rdata_out, mem_wdata;
    logic                busy, mem_en, mem_we;
    logic [ADDR_W-1:0]   mem_addr;

    logic [3:0]          gnt1, rdy1, gnt4, rdy4;
    logic [DATA_W-1:0]   rd1, rd4, wd1, wd4;
    logic                busy1, en1, we1, busy4, en4, we4;
    logic [ADDR_W-1:0]   ad1, ad4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last, n, r1, r4;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2)) dut (
        .clock(clock), .reset(reset), .req(req), .we_in(we_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .ready(ready),
        .rdata_out(rdata_out), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .req(req_l), .we_in(4'b0000),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt1), .ready(rdy1),
        .rdata_out(rd1), .busy(busy1), .mem_en(en1), .mem_we(we1),
        .mem_addr(ad1), .mem_wdata(wd1), .mem_rdata(16'h0000)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(4)) dut4 (
        .clock(clock), .reset(reset), .req(req_l), .we_in(4'b0000),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt4), .ready(rdy4),
        .rdata_out(rd4), .busy(busy4), .mem_en(en4), .mem_we(we4),
        .mem_addr(ad4), .mem_wdata(wd4), .mem_rdata(16'h0000)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; req = 4'b0; req_l = 4'b0; we_in = 4'b0;
        addr_in = '0; wdata_in = '0; mem_rdata = '0;

        // Asynchronous reset, checked before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_rdata", rdata_out, 16'h0000);
        tick; tick;
        reset = 1'b1;

        // Single read: cycle 0 IDLE with req.
        addr_in[0*ADDR_W +: ADDR_W] = 8'h10;
        req = 4'b0001;
        chk("rd_c0_busy", busy, 1'b0);
        tick;                                   // cycle 1: ISSUE
        chk("rd_issue_en", mem_en, 1'b1);
        chk("rd_issue_addr", mem_addr, 8'h10);
        chk("rd_issue_we", mem_we, 1'b0);
        chk("rd_gnt", gnt, 4'b0001);
        tick;                                   // cycle 2: WAIT
        chk("rd_wait_en", mem_en, 1'b0);
        chk("rd_wait_busy", busy, 1'b1);
        tick;                                   // cycle 3: WAIT, data valid
        mem_rdata = 16'hBEEF;
        chk("rd_no_ready", ready, 4'b0000);
        tick;                                   // cycle 4: DONE
        mem_rdata = 16'h0000;
        chk("rd_ready", ready, 4'b0001);
        chk("rd_data", rdata_out, 16'hBEEF);
        req = 4'b0000;
        tick;                                   // cycle 5: IDLE
        chk("rd_idle_rdy", ready, 4'b0000);
        chk("rd_idle_gnt", gnt, 4'b0000);

        // Write from core 2.
        we_in = 4'b0100;
        addr_in[2*ADDR_W +: ADDR_W]  = 8'h3F;
        wdata_in[2*DATA_W +: DATA_W] = 16'h1234;
        req = 4'b0100;
        tick;                                   // ISSUE
        chk("wr_en", mem_en, 1'b1);
        chk("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, 8'h3F);
        chk("wr_wdata", mem_wdata, 16'h1234);
        chk("wr_gnt", gnt, 4'b0100);
        mem_rdata = 16'h5555;
        tick; tick; tick;                       // DONE
        chk("wr_ready", ready, 4'b0100);
        chk("wr_rdata_keep", rdata_out, 16'hBEEF);
        chk("wr_en_done", mem_en, 1'b0);
        chk("wr_addr_hold", mem_addr, 8'h3F);
        req = 4'b0000; we_in = 4'b0000;
        mem_rdata = 16'hA5A5;
        tick;

        // Contention: reset pointer to 0, all four request.
        reset = 1'b0; #1; reset = 1'b1;
        req = 4'b1111;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (ready == 4'b0000 && n < 20) begin
                tick;
                n++;
            end
            chk("cont_order", ready, 32'(1 << k));
            chk("cont_gnt", gnt, 32'(1 << k));
            if (k > 0) chk("cont_gap", 32'(cyc - last), 32'd5);
            last = cyc;
            req[k] = 1'b0;
            tick;
        end
        chk("cont_rdata", rdata_out, 16'hA5A5);

        // Fairness: cores 0 and 2 keep requesting.
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (ready == 4'b0000 && n < 20) begin
                tick;
                n++;
            end
            chk("fair_order", ready, (k % 2 == 0) ? 32'h1 : 32'h4);
            tick;
        end
        req = 4'b0000;
        tick;

        // Reset in WAIT aborts; core 3 then completes normally.
        addr_in[3*ADDR_W +: ADDR_W] = 8'h77;
        req = 4'b1000;
        tick;                                   // ISSUE
        chk("ab_gnt", gnt, 4'b1000);
        tick;                                   // WAIT
        reset = 1'b0;
        #1;
        chk("ab_gnt0", gnt, 4'b0000);
        chk("ab_busy0", busy, 1'b0);
        chk("ab_addr0", mem_addr, 8'h00);
        chk("ab_rdata0", rdata_out, 16'h0000);
        tick;
        chk("ab_no_ready", ready, 4'b0000);
        #2 reset = 1'b1;                        // cycle 0 of the retry
        tick;
        chk("ab2_gnt", gnt, 4'b1000);
        chk("ab2_en", mem_en, 1'b1);
        chk("ab2_addr", mem_addr, 8'h77);
        tick; tick; tick;
        chk("ab2_ready", ready, 4'b1000);
        chk("ab2_rdata", rdata_out, 16'hA5A5);
        req = 4'b0000;
        tick;

        // Latency of MEM_LAT=1 and MEM_LAT=4 instances.
        req_l = 4'b0001;
        r1 = 0; r4 = 0;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (rdy1 != 4'b0000 && r1 == 0) r1 = c;
            if (rdy4 != 4'b0000 && r4 == 0) r4 = c;
        end
        req_l = 4'b0000;
        chk("lat1_cycle", r1, 32'd3);
        chk("lat4_cycle", r4, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 8, address width
- DATA_W, 16, data width
- MEM_LAT, 2, shared-memory read latency in cycles (legal range 1..15)

REQ-002 Ports SHALL be, one per line:
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  4  per-core request level, bit i = core i
- we_in  in  4  per-core write enable (1 = write, 0 = read)
- addr_in  in  4*ADDR_W  per-core address, core i at bits [i*ADDR_W +: ADDR_W]
- wdata_in  in  4*DATA_W  per-core write data, same packing
- gnt  out  4  one-hot, owner of the memory
- ready  out  4  one-hot, single-cycle completion pulse
- rdata_out  out  DATA_W  read data of the last completed read
- busy  out  1  a transaction is in progress
- mem_en  out  1  memory strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-004 IDLE: if any eligible req bit is set, the block SHALL choose a winner by round-robin starting at ptr and going ptr, ptr+1, ... mod 4.
REQ-005 On leaving IDLE, the block SHALL latch the winner's addr_in, wdata_in and we_in, then go to ISSUE; with no eligible request it SHALL stay in IDLE.
REQ-006 ISSUE SHALL last exactly one cycle: mem_en=1, with mem_we/mem_addr/mem_wdata driven from the latched values; next state WAIT with cnt=MEM_LAT-1.
REQ-007 mem_en SHALL be 0 in all states other than ISSUE; mem_addr/mem_wdata/mem_we SHALL hold their latched values outside ISSUE.
REQ-008 WAIT: if cnt==0, the block SHALL go to DONE and, for a read, capture mem_rdata into rdata_out on that edge; otherwise it SHALL decrement cnt.
REQ-009 WAIT SHALL last exactly MEM_LAT cycles.
REQ-010 DONE SHALL last one cycle: ready[winner]=1, ptr <= (winner+1) mod 4, next state IDLE.
REQ-011 gnt SHALL equal the one-hot winner in ISSUE, WAIT and DONE, and SHALL be 0 in IDLE.
REQ-012 busy SHALL be 1 in ISSUE, WAIT and DONE.
REQ-013 Writes SHALL NOT modify rdata_out; rdata_out SHALL hold until the next read completes.
REQ-014 Latency: a request seen in IDLE at cycle 0 SHALL give ISSUE at cycle 1, WAIT at cycles 2..1+MEM_LAT and ready at cycle 2+MEM_LAT.
REQ-015 The memory SHALL present mem_rdata valid in cycle 1+MEM_LAT.
REQ-016 Eligibility: in the IDLE cycle that immediately follows DONE, the port just served SHALL be masked; in all other IDLE cycles, all req bits SHALL be eligible.
REQ-017 Requesters SHALL hold req, we_in, addr_in and wdata_in until their ready pulse.
REQ-018 Changes to req after latching SHALL NOT affect the transaction in flight; a dropped req SHALL still complete with a ready pulse.
REQ-019 Maximum throughput SHALL be one transaction per 3+MEM_LAT cycles; no two ready pulses SHALL be closer together than that.
REQ-020 At most one bit of gnt and of ready SHALL ever be set.

Reset
REQ-021 When reset=0, the block SHALL immediately (asynchronously) set: state=IDLE, ptr=0, cnt=0, gnt=0, ready=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_out=0.
REQ-022 Reset asserted mid-transaction SHALL abort it with no ready pulse; after release, the first arbitration SHALL start at ptr=0.

Verification
REQ-023 Single read: req=0001, addr0=0x10, mem_rdata=0xBEEF in cycle 3 (MEM_LAT=2) -> mem_en=1 only in cycle 1 with mem_addr=0x10; ready=0001 in cycle 4; rdata_out=0xBEEF.
REQ-024 Contention: req=1111 held, each port dropping req after its ready -> ready order core0, core1, core2, core3, with consecutive pulses 5 cycles apart.
REQ-025 Fairness: core0 and core2 request continuously (re-asserting req right after ready) -> grants alternate 0, 2, 0, 2; core0 is never granted twice in a row.
REQ-026 Write: req=0100, we_in[2]=1, addr2=0x3F, wdata2=0x1234 -> mem_en=1, mem_we=1, mem_addr=0x3F, mem_wdata=0x1234 in ISSUE; ready=0100; rdata_out unchanged.
REQ-027 Reset during WAIT -> all outputs 0 immediately, no ready pulse; with req=1000 re-asserted after release, core3 is granted and the sequence completes normally.
REQ-028 MEM_LAT=1 and MEM_LAT=4 builds -> ready at cycle 3 and cycle 6 respectively after a request seen in cycle 0.
